// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. It sends one command byte to the mouse
//   over the shared clock/data pins, which are open-drain. The block only
//   drives pull-down enables. The top level builds the tristate as
//   pin = oe ? 1'b0 : 1'bz.
//   Tx_Busy lets the receiver ignore the frame that this block sends.
//
//   Optional feature macro: PS2_TX_RETRY_EN.
//   When the macro is defined, a NACK or a timeout restarts the frame from the
//   inhibit phase. Up to 2 retries are made, and Tx_Error pulses only after the
//   third failure.
//
// Ports
//   Clk         in   system clock (50 MHz nominal)
//   Reset_n     in   asynchronous reset, active low
//   Tx_Data     in   [7:0] command byte, latched when Tx_Start is accepted
//   Tx_Start    in   1-cycle request, accepted only while idle
//   PS2_CLK_in  in   raw PS/2 clock pin level (asynchronous)
//   PS2_DAT_in  in   raw PS/2 data pin level (asynchronous)
//   PS2_CLK_oe  out  1 = pull the clock line low
//   PS2_DAT_oe  out  1 = pull the data line low
//   Tx_Busy     out  high from an accepted request until the frame completes
//   Tx_Done     out  1-cycle pulse: the device ACKed the byte
//   Tx_Error    out  1-cycle pulse: NACK or watchdog timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Start,
  input  logic       PS2_CLK_in,
  input  logic       PS2_DAT_in,
  output logic       PS2_CLK_oe,
  output logic       PS2_DAT_oe,
  output logic       Tx_Busy,
  output logic       Tx_Done,
  output logic       Tx_Error
);

  localparam int MAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE, S_FAIL
  } state_t;

  // Odd parity over the command byte.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Increment that saturates at all-ones, so the counters never wrap.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  state_t         state_r, state_s;
  logic [10:0]    shreg_r, shreg_s;   // {stop, parity, data[7:0], start}
  logic [3:0]     idx_r, idx_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [CW-1:0]  wd_r, wd_s;
  logic           clk_meta_r, clk_sync_r, clk_prev_r;
  logic           dat_meta_r, dat_sync_r;
  logic           clk_oe_r, dat_oe_r, busy_r, done_r, err_r;
  logic           clk_oe_s, dat_oe_s, busy_s, done_s, err_s;
  logic           fall_s, fail_s, timeout_s;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]     retry_r, retry_s;
`endif

  assign fall_s    = clk_prev_r & ~clk_sync_r;
  assign timeout_s = (wd_r >= CW'(TIMEOUT_CYCLES - 1));

  // Next-state, counter and output decode. Outputs are computed from the next
  // state so that the registered outputs line up with the state register.
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    idx_s   = idx_r;
    cnt_s   = sat_inc(cnt_r);
    wd_s    = sat_inc(wd_r);
    done_s  = 1'b0;
    fail_s  = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_s = retry_r;
`endif
    case (state_r)
      S_IDLE: begin
        cnt_s = '0;
        wd_s  = '0;
        idx_s = 4'd0;
        if (Tx_Start) begin
          // The start bit at index 0 keeps data low until the first device fall.
          shreg_s = {1'b1, odd_parity(Tx_Data), Tx_Data, 1'b0};
          state_s = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_s = 2'd0;
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
      S_INHIBIT: begin
        wd_s = '0;
        if (cnt_r >= CW'(INHIBIT_CYCLES - 1)) begin
          state_s = S_REQ;
          cnt_s   = '0;
        end else begin
          state_s = S_INHIBIT;
        end
      end
      S_REQ: begin
        wd_s = '0;
        if (cnt_r >= CW'(SETUP_CYCLES - 1)) begin
          state_s = S_SHIFT;
          idx_s   = 4'd0;
        end else begin
          state_s = S_REQ;
        end
      end
      S_SHIFT: begin
        // Fall k puts bit k of shreg on the line. The stop bit (release) is
        // already what ACK drives, so the 10th fall moves directly to ACK.
        if (fall_s) begin
          wd_s = '0;
          if (idx_r == 4'd9) begin
            state_s = S_ACK;
          end else begin
            idx_s = idx_r + 4'd1;
          end
        end else if (timeout_s) begin
          fail_s = 1'b1;
        end else begin
          state_s = S_SHIFT;
        end
      end
      S_ACK: begin
        if (fall_s) begin
          wd_s = '0;
          if (!dat_sync_r) begin
            state_s = S_WAIT_IDLE;
          end else begin
            fail_s = 1'b1;
          end
        end else if (timeout_s) begin
          fail_s = 1'b1;
        end else begin
          state_s = S_ACK;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync_r && dat_sync_r) begin
          done_s  = 1'b1;
          state_s = S_IDLE;
        end else if (fall_s) begin
          wd_s = '0;
        end else if (timeout_s) begin
          fail_s = 1'b1;
        end else begin
          state_s = S_WAIT_IDLE;
        end
      end
      S_FAIL: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    if (fail_s) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_r != 2'd2) begin
        retry_s = retry_r + 2'd1;
        state_s = S_INHIBIT;
        cnt_s   = '0;
      end else begin
        state_s = S_FAIL;
      end
`else
      state_s = S_FAIL;
`endif
    end else begin
      state_s = state_s;
    end

    // The done/error pulse occurs in the same cycle that Busy falls.
    clk_oe_s = (state_s == S_INHIBIT) || (state_s == S_REQ);
    dat_oe_s = (state_s == S_REQ) || ((state_s == S_SHIFT) && !shreg_s[idx_s]);
    busy_s   = (state_s != S_IDLE) && (state_s != S_FAIL);
    err_s    = (state_s == S_FAIL);
  end

  // State, datapath, pin synchronizers and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r    <= S_IDLE;
      shreg_r    <= 11'd0;
      idx_r      <= 4'd0;
      cnt_r      <= '0;
      wd_r       <= '0;
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      clk_prev_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
      clk_oe_r   <= 1'b0;
      dat_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_r    <= 2'd0;
`endif
    end else begin
      state_r    <= state_s;
      shreg_r    <= shreg_s;
      idx_r      <= idx_s;
      cnt_r      <= cnt_s;
      wd_r       <= wd_s;
      clk_meta_r <= PS2_CLK_in;
      clk_sync_r <= clk_meta_r;
      clk_prev_r <= clk_sync_r;
      dat_meta_r <= PS2_DAT_in;
      dat_sync_r <= dat_meta_r;
      clk_oe_r   <= clk_oe_s;
      dat_oe_r   <= dat_oe_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
`ifdef PS2_TX_RETRY_EN
      retry_r    <= retry_s;
`endif
    end
  end

  assign PS2_CLK_oe = clk_oe_r;
  assign PS2_DAT_oe = dat_oe_r;
  assign Tx_Busy    = busy_r;
  assign Tx_Done    = done_r;
  assign Tx_Error   = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//   Directed bench for ps2_host_tx. A PS/2 device model shares wired-AND
//   clock and data lines with the DUT. Each request pushes its expected
//   outcome into a queue. A monitor pops that queue on every Tx_Done/Tx_Error
//   pulse and compares the result.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int SET = 8;
  localparam int TO  = 600;
  localparam int H   = 20;    // device half clock period, in Clk cycles
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] Tx_Data = 8'h00;
  logic       Tx_Start = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       PS2_CLK_oe, PS2_DAT_oe, Tx_Busy, Tx_Done, Tx_Error;
  logic       ps2_clk, ps2_dat;

  assign ps2_clk = ~(PS2_CLK_oe | dev_clk_low);
  assign ps2_dat = ~(PS2_DAT_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Tx_Data(Tx_Data), .Tx_Start(Tx_Start),
    .PS2_CLK_in(ps2_clk), .PS2_DAT_in(ps2_dat),
    .PS2_CLK_oe(PS2_CLK_oe), .PS2_DAT_oe(PS2_DAT_oe),
    .Tx_Busy(Tx_Busy), .Tx_Done(Tx_Done), .Tx_Error(Tx_Error)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic       is_err;
    logic [9:0] frame;   // {stop, parity, data} as seen by the device
  } exp_t;
  exp_t exp_q[$];

  logic [9:0] rx_frame = 10'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge Clk);
    Tx_Data  = b;
    Tx_Start = 1'b1;
    @(posedge Clk);
    #1 Tx_Start = 1'b0;
  endtask

  // Device model. It waits for the host request, then produces 11 clock
  // pulses. It samples data on rising edges 1..10 and ACKs when ack=1. If
  // abort_at is nonzero, Reset_n is asserted once the device clock has been
  // low for that fall long enough for the host to detect it.
  task automatic dev_frame(input bit ack, input int abort_at,
                           output int inh_n, output int req_n);
    bit got;
    got = 1'b0; inh_n = 0; req_n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clk);
      if (PS2_CLK_oe && !PS2_DAT_oe) inh_n++;
      else if (PS2_CLK_oe && PS2_DAT_oe) req_n++;
      else if (!PS2_CLK_oe && PS2_DAT_oe) begin got = 1'b1; break; end
    end
    check("request_seen", got, 1);
    if (!got) return;
    repeat (H) @(negedge Clk);
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge Clk);
      if (k == abort_at) begin
        #2 Reset_n = 1'b0;
        #1 check("reset_oe_clear", {PS2_CLK_oe, PS2_DAT_oe}, 0);
        check("reset_busy_clear", Tx_Busy, 0);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        return;
      end
      dev_clk_low = 1'b0;
      if (k <= 10) rx_frame[k-1] = ps2_dat;
      if (k == 10 && ack) dev_dat_low = 1'b1;
      if (k == 11) dev_dat_low = 1'b0;
      repeat (H) @(negedge Clk);
    end
  endtask

  // Waits for a fresh clock release: first the inhibit, then clk_oe low with data low.
  task automatic wait_release(output bit got);
    bit seen_inh;
    seen_inh = 1'b0; got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (PS2_CLK_oe) seen_inh = 1'b1;
      else if (seen_inh && PS2_DAT_oe) begin got = 1'b1; break; end
    end
  endtask

  // Scoreboard monitor.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset_n === 1'b1 && (Tx_Done === 1'b1 || Tx_Error === 1'b1)) begin
        check("done_err_exclusive", Tx_Done & Tx_Error, 0);
        check("busy_at_pulse", Tx_Busy, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: got done=%0b err=%0b, expected no pulse", Tx_Done, Tx_Error);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_err", Tx_Error, e.is_err);
          if (!e.is_err) check("frame_bits", rx_frame, e.frame);
        end
        @(negedge Clk);
        check("pulse_width", Tx_Done | Tx_Error, 0);
        check("busy_after_pulse", Tx_Busy, 0);
      end
    end
  end

  initial begin : stim
    int  inh, req, t0;
    bit  got, seen;

    // Reset state
    repeat (3) @(negedge Clk);
    check("reset_outputs", {PS2_CLK_oe, PS2_DAT_oe, Tx_Busy, Tx_Done, Tx_Error}, 0);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle_outputs", {PS2_CLK_oe, PS2_DAT_oe, Tx_Busy, Tx_Done, Tx_Error}, 0);

    // T1: 0xF4, odd parity 0
    exp_q.push_back('{1'b0, 10'h2F4});
    send(8'hF4);
    check("busy_after_start", Tx_Busy, 1);
    dev_frame(1'b1, 0, inh, req);
    check("inhibit_cycles", inh, INH);
    check("setup_cycles", req, SET);
    repeat (20) @(negedge Clk);

    // T2: 0xFF, parity 1
    exp_q.push_back('{1'b0, 10'h3FF});
    send(8'hFF);
    dev_frame(1'b1, 0, inh, req);
    check("inhibit_cycles_ff", inh, INH);
    repeat (20) @(negedge Clk);

    // T3: NACK on the 11th fall
    exp_q.push_back('{1'b1, 10'h000});
    send(8'hAA);
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_frame(1'b0, 0, inh, req);
      check("nack_frame_bits", rx_frame, 10'h3AA);
    end
    repeat (20) @(negedge Clk);

    // T4: the device never clocks
    exp_q.push_back('{1'b1, 10'h000});
    send(8'h55);
    t0 = 0;
    for (int a = 0; a < ATTEMPTS; a++) begin
      wait_release(got);
      check("timeout_release_seen", got, 1);
      t0 = cyc;
    end
    seen = 1'b0;
    for (int i = 0; i < TO + 100; i++) begin
      @(negedge Clk);
      if (Tx_Error) begin seen = 1'b1; break; end
    end
    check("timeout_error_seen", seen, 1);
    check("timeout_cycles", cyc - t0, TO);
    check("timeout_lines_released", {PS2_CLK_oe, PS2_DAT_oe}, 0);
    repeat (20) @(negedge Clk);

    // T5: a second start during SHIFT is ignored, and the data change has no effect
    exp_q.push_back('{1'b0, 10'h2F4});
    send(8'hF4);
    fork
      dev_frame(1'b1, 0, inh, req);
      begin
        repeat (INH + SET + 100) @(negedge Clk);
        Tx_Data  = 8'h00;
        Tx_Start = 1'b1;
        @(posedge Clk);
        #1 Tx_Start = 1'b0;
      end
    join
    repeat (INH + 40) @(negedge Clk);
    check("no_requeued_frame", {Tx_Busy, PS2_CLK_oe}, 0);

    // T6: reset after the 4th fall, then a clean frame (0x00, parity 1)
    send(8'hF4);
    dev_frame(1'b1, 4, inh, req);
    repeat (10) @(negedge Clk);
    check("post_reset_idle", {PS2_CLK_oe, PS2_DAT_oe, Tx_Busy}, 0);
    exp_q.push_back('{1'b0, 10'h300});
    send(8'h00);
    dev_frame(1'b1, 0, inh, req);
    check("inhibit_after_reset", inh, INH);

    repeat (50) @(negedge Clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
